reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Circular in-order commit buffer for the Tomasulo core. Sits downstream of issue and alongside the reservation stations. It allocates one entry per issued instruction and hands the entry id (`tail`) to the RS/LSB. It answers operand-ready queries, captures ALU and LSB results, and retires one instruction per cycle to the register file. On a mispredicted branch it flushes the pipeline with a redirect PC.

## Interface
- `BITS`, 4, log2 of entry count
- `SIZE`, 16, entry count; must equal 1<<BITS

- `clk_in` in 1: system clock
- `rst_n_in` in 1: asynchronous, active-low reset
- `rdy_in` in 1: pause when low
- `issue_valid` in 1: allocate an entry this cycle
- `issue_type` in 2: 00 reg-write, 01 store, 10 branch, 11 reserved (treated as reg-write)
- `issue_rd` in 5: destination register
- `issue_pc` in 32: instruction PC
- `issue_pred_taken` in 1: predictor decision
- `tail` out BITS: id the next issue receives
- `full` out 1, `empty` out 1
- `qry1_id`, `qry2_id` in BITS: operand producer ids
- `qry1_busy`, `qry2_busy` out 1: 1 = value not yet available
- `qry1_value`, `qry2_value` out 32
- `alu_valid` in 1, `alu_id` in BITS, `alu_value` in 32, `alu_taken` in 1, `alu_target` in 32: ALU result; the last two are meaningful for branches only
- `lsb_valid` in 1, `lsb_id` in BITS, `lsb_value` in 32: LSB result
- `commit_valid` out 1, `commit_id` out BITS, `commit_rd` out 5, `commit_value` out 32
- `store_commit` out 1, `store_commit_id` out BITS: store at head may write memory
- `flush` out 1, `flush_pc` out 32

## Operation
- Per-entry state:
  - busy, ready, type, rd, value, pc, pred, taken, target
  - head/tail pointers of BITS bits that wrap naturally
  - count of BITS+1 bits
- Issue: on `issue_valid && !full`, write the entry at tail with busy=1, ready=0, then tail+1. `issue_valid` while full is ignored; issue must hold it.
- Writeback:
  - On `alu_valid`, or on `lsb_valid`, the entry at `*_id` gets ready=1 and value captured; ALU also captures taken/target.
  - Both ports may hit different ids in one cycle.
  - A hit on a non-busy entry is ignored.
- Commit: evaluated every cycle on the head entry. If busy && ready, retire it: busy=0, head+1, exactly one per cycle.
  - reg-write: pulse `commit_valid` with rd/value/id. rd=0 is still reported; the register file ignores x0.
  - store: pulse `store_commit` and `store_commit_id`. No `commit_valid`.
  - branch, taken==pred: silent retire.
  - branch, taken!=pred: pulse `flush`. `flush_pc` = taken ? target : pc+4. Clear every entry; head=tail=count=0.
- Simultaneous events:
  - issue+commit in one cycle: count unchanged.
  - A flush cycle drops any same-cycle issue and writeback.
  - Writeback to the head and commit of the head in the same cycle is not possible; commit sees pre-edge state.
- `full` = count==SIZE; `empty` = count==0. Both are combinational from state.
- Query: `qryN_busy` = !(busy && ready); `qryN_value` = stored value. Query outputs are combinational.
- `rdy_in` low: all state holds; `commit_valid`, `store_commit` and `flush` deassert.

## Timing
- Reset (async assert, sync deassert expected externally) gives:
  - all entries cleared, head=tail=count=0
  - `tail`=0, `full`=0, `empty`=1
  - `commit_*`, `store_commit*`, `flush`, `flush_pc` all 0
  - `qryN_busy`=1, `qryN_value`=0
- Reset mid-operation discards all entries immediately.
- Commit/flush outputs are registered single-cycle pulses.
- Latency:
  - issue at edge E0
  - earliest writeback at edge E1
  - head becomes retirable after E1
  - commit pulse appears after edge E2
- Minimum issue→commit is 2 edges.
- `tail` updates after the issuing edge. The RS samples `tail` in the same cycle it asserts issue.

## Configuration
- `ROB_BYPASS_EN` defined: query ports forward same-cycle results. If `alu_valid && alu_id==qryN_id`, busy=0 and value=`alu_value`; else the LSB port equivalent; ALU has priority.
- `ROB_BYPASS_EN` undefined: results are visible to queries only from the cycle after the writeback edge.

## Structure
- Package `rob_pkg`:
  - `ROB_BITS`/`ROB_SIZE` constants
  - 2-bit entry-type typedef and encodings
  - entry struct
- One sub-module: `branch_resolve`. Combinational; takes pred, taken, target, pc; produces mispredict and redirect PC.

## Test plan
- Issue 16 reg-write entries with no writeback → `full`=1, `tail`=0 after wrap. 17th issue is ignored; count stays 16.
- Issue id0 (rd=5), ALU writeback id0 value 0x1234 → `commit_valid` pulse, `commit_rd`=5, `commit_value`=0x1234, two edges after issue.
- Issue ids 0,1. Write back id1 first (0xB), then id0 (0xA) → commits in order: 0xA then 0xB.
- Branch at pc 0x100, pred=0, alu_taken=1, target 0x200, with 3 younger entries → `flush`=1, `flush_pc`=0x200, `empty`=1, `tail`=0. A same-cycle issue is dropped.
- Query id3 in the same cycle as `alu_valid` id3 value 0x55 → with `ROB_BYPASS_EN`: busy=0, value=0x55. Without: busy=1, then 0/0x55 next cycle.
- Assert `rst_n_in` low with 8 entries live, mid-cycle → immediately `empty`=1, `commit_valid`=0, `flush`=0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer: depth constants, entry-type
// encodings and the per-entry record.
// Latency: n/a (types only). Backpressure: n/a.
package rob_pkg;

  localparam int ROB_BITS = 4;
  localparam int ROB_SIZE = 1 << ROB_BITS;

  // Reserved encoding retires exactly like a register write.
  typedef enum logic [1:0] {
    ROB_T_REG    = 2'b00,
    ROB_T_STORE  = 2'b01,
    ROB_T_BRANCH = 2'b10,
    ROB_T_RSVD   = 2'b11
  } rob_type_e;

  typedef struct packed {
    logic        busy;
    logic        ready;
    rob_type_e   typ;
    logic [4:0]  rd;
    logic [31:0] value;
    logic [31:0] pc;
    logic        pred;
    logic        taken;
    logic [31:0] target;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of every ROB-facing signal: issue, operand query, ALU/LSB writeback,
// commit/store-commit and flush. master = core side, slave = reorder buffer.
// Latency/backpressure are properties of the ROB; issue holds while full=1.
interface reorder_buffer_if
  import rob_pkg::*;
#(
  parameter int BITS = ROB_BITS
) ();

  // issue
  logic            issue_valid;
  logic [1:0]      issue_type;
  logic [4:0]      issue_rd;
  logic [31:0]     issue_pc;
  logic            issue_pred_taken;
  logic [BITS-1:0] tail;
  logic            full;
  logic            empty;

  // operand queries
  logic [BITS-1:0] qry1_id;
  logic [BITS-1:0] qry2_id;
  logic            qry1_busy;
  logic            qry2_busy;
  logic [31:0]     qry1_value;
  logic [31:0]     qry2_value;

  // writeback
  logic            alu_valid;
  logic [BITS-1:0] alu_id;
  logic [31:0]     alu_value;
  logic            alu_taken;
  logic [31:0]     alu_target;
  logic            lsb_valid;
  logic [BITS-1:0] lsb_id;
  logic [31:0]     lsb_value;

  // retire
  logic            commit_valid;
  logic [BITS-1:0] commit_id;
  logic [4:0]      commit_rd;
  logic [31:0]     commit_value;
  logic            store_commit;
  logic [BITS-1:0] store_commit_id;
  logic            flush;
  logic [31:0]     flush_pc;

  modport master (
    output issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken,
    output qry1_id, qry2_id,
    output alu_valid, alu_id, alu_value, alu_taken, alu_target,
    output lsb_valid, lsb_id, lsb_value,
    input  tail, full, empty,
    input  qry1_busy, qry2_busy, qry1_value, qry2_value,
    input  commit_valid, commit_id, commit_rd, commit_value,
    input  store_commit, store_commit_id, flush, flush_pc
  );

  modport slave (
    input  issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken,
    input  qry1_id, qry2_id,
    input  alu_valid, alu_id, alu_value, alu_taken, alu_target,
    input  lsb_valid, lsb_id, lsb_value,
    output tail, full, empty,
    output qry1_busy, qry2_busy, qry1_value, qry2_value,
    output commit_valid, commit_id, commit_rd, commit_value,
    output store_commit, store_commit_id, flush, flush_pc
  );

endinterface

// File: rtl/reorder_buffer_branch_resolve.sv
// Branch outcome check for the entry at the ROB head.
// Latency: combinational. Backpressure: none.
// Ports: i_pred/i_taken/i_target/i_pc in; o_mispredict, o_redirect_pc out.
module branch_resolve (
  input  logic        i_pred,
  input  logic        i_taken,
  input  logic [31:0] i_target,
  input  logic [31:0] i_pc,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc
);

  assign o_mispredict  = i_taken != i_pred;
  // Fetch resumes on the path the branch actually took.
  assign o_redirect_pc = i_taken ? i_target : i_pc + 32'd4;

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order commit buffer: allocates at tail, captures ALU/LSB results,
// retires one head entry per cycle, flushes everything on a branch mispredict.
// Latency: issue->commit pulse minimum 2 edges; commit/flush are registered
// single-cycle pulses; tail/full/empty/query outputs are combinational from state.
// Backpressure: issue_valid is ignored while full (issuer holds it); rdy_in low
// freezes all state and suppresses the retire pulses.
// Ports: clk_in, rst_n_in (async active-low), rdy_in, bus (reorder_buffer_if.slave).
// Build option: define ROB_BYPASS_EN to forward same-cycle writeback results
// onto the query ports (ALU has priority over LSB).
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int BITS = ROB_BITS,
  parameter int SIZE = ROB_SIZE   // must equal 1 << BITS
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  reorder_buffer_if.slave  bus
);

  rob_entry_t      r_rob [SIZE];
  logic [BITS-1:0] r_head;
  logic [BITS-1:0] r_tail;
  logic [BITS:0]   r_count;

  logic            r_commit_valid;
  logic [BITS-1:0] r_commit_id;
  logic [4:0]      r_commit_rd;
  logic [31:0]     r_commit_value;
  logic            r_store_commit;
  logic [BITS-1:0] r_store_commit_id;
  logic            r_flush;
  logic [31:0]     r_flush_pc;

  rob_entry_t      w_head_ent;
  logic            w_full;
  logic            w_empty;
  logic            w_retire;
  logic            w_br_mispredict;
  logic [31:0]     w_redirect_pc;
  logic            w_flush_now;
  logic            w_issue;
  logic            w_alu_hit;
  logic            w_lsb_hit;

  assign w_head_ent = r_rob[r_head];
  assign w_full     = r_count == (BITS+1)'(SIZE);
  assign w_empty    = r_count == '0;
  assign w_retire   = w_head_ent.busy && w_head_ent.ready;
  assign w_issue    = bus.issue_valid && !w_full;
  // Results for entries that are not allocated (stale ids) are dropped.
  assign w_alu_hit  = bus.alu_valid && r_rob[bus.alu_id].busy;
  assign w_lsb_hit  = bus.lsb_valid && r_rob[bus.lsb_id].busy;

  branch_resolve u_branch_resolve (
    .i_pred        (w_head_ent.pred),
    .i_taken       (w_head_ent.taken),
    .i_target      (w_head_ent.target),
    .i_pc          (w_head_ent.pc),
    .o_mispredict  (w_br_mispredict),
    .o_redirect_pc (w_redirect_pc)
  );

  assign w_flush_now = w_retire && (w_head_ent.typ == ROB_T_BRANCH) && w_br_mispredict;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < SIZE; i++) begin
        r_rob[i] <= '0;
      end
      r_head            <= '0;
      r_tail            <= '0;
      r_count           <= '0;
      r_commit_valid    <= 1'b0;
      r_commit_id       <= '0;
      r_commit_rd       <= '0;
      r_commit_value    <= '0;
      r_store_commit    <= 1'b0;
      r_store_commit_id <= '0;
      r_flush           <= 1'b0;
      r_flush_pc        <= '0;
    end else begin
      // Retire strobes are one-cycle pulses; payload registers hold.
      r_commit_valid <= 1'b0;
      r_store_commit <= 1'b0;
      r_flush        <= 1'b0;

      if (rdy_in) begin
        if (w_flush_now) begin
          // Mispredict wins over everything else in this cycle, including
          // any issue or writeback arriving alongside it.
          for (int i = 0; i < SIZE; i++) begin
            r_rob[i] <= '0;
          end
          r_head     <= '0;
          r_tail     <= '0;
          r_count    <= '0;
          r_flush    <= 1'b1;
          r_flush_pc <= w_redirect_pc;
        end else begin
          if (w_alu_hit) begin
            r_rob[bus.alu_id].ready  <= 1'b1;
            r_rob[bus.alu_id].value  <= bus.alu_value;
            r_rob[bus.alu_id].taken  <= bus.alu_taken;
            r_rob[bus.alu_id].target <= bus.alu_target;
          end
          if (w_lsb_hit) begin
            r_rob[bus.lsb_id].ready <= 1'b1;
            r_rob[bus.lsb_id].value <= bus.lsb_value;
          end

          if (w_issue) begin
            r_rob[r_tail].busy   <= 1'b1;
            r_rob[r_tail].ready  <= 1'b0;
            r_rob[r_tail].typ    <= rob_type_e'(bus.issue_type);
            r_rob[r_tail].rd     <= bus.issue_rd;
            r_rob[r_tail].value  <= '0;
            r_rob[r_tail].pc     <= bus.issue_pc;
            r_rob[r_tail].pred   <= bus.issue_pred_taken;
            r_rob[r_tail].taken  <= 1'b0;
            r_rob[r_tail].target <= '0;
            r_tail               <= r_tail + BITS'(1);
          end

          // Head decision uses pre-edge state, so a result landing this
          // edge is only retired on the next one.
          if (w_retire) begin
            r_rob[r_head].busy <= 1'b0;
            r_head             <= r_head + BITS'(1);
            case (w_head_ent.typ)
              ROB_T_STORE: begin
                r_store_commit    <= 1'b1;
                r_store_commit_id <= r_head;
              end
              ROB_T_BRANCH: begin
                // correctly predicted: nothing to report
              end
              default: begin
                r_commit_valid <= 1'b1;
                r_commit_id    <= r_head;
                r_commit_rd    <= w_head_ent.rd;
                r_commit_value <= w_head_ent.value;
              end
            endcase
          end

          r_count <= r_count + (BITS+1)'(w_issue) - (BITS+1)'(w_retire);
        end
      end
    end
  end

  // Operand queries
  logic        w_q1_busy;
  logic        w_q2_busy;
  logic [31:0] w_q1_value;
  logic [31:0] w_q2_value;

  always_comb begin
    w_q1_busy  = !(r_rob[bus.qry1_id].busy && r_rob[bus.qry1_id].ready);
    w_q1_value = r_rob[bus.qry1_id].value;
    w_q2_busy  = !(r_rob[bus.qry2_id].busy && r_rob[bus.qry2_id].ready);
    w_q2_value = r_rob[bus.qry2_id].value;
`ifdef ROB_BYPASS_EN
    if (bus.alu_valid && bus.alu_id == bus.qry1_id) begin
      w_q1_busy  = 1'b0;
      w_q1_value = bus.alu_value;
    end else if (bus.lsb_valid && bus.lsb_id == bus.qry1_id) begin
      w_q1_busy  = 1'b0;
      w_q1_value = bus.lsb_value;
    end
    if (bus.alu_valid && bus.alu_id == bus.qry2_id) begin
      w_q2_busy  = 1'b0;
      w_q2_value = bus.alu_value;
    end else if (bus.lsb_valid && bus.lsb_id == bus.qry2_id) begin
      w_q2_busy  = 1'b0;
      w_q2_value = bus.lsb_value;
    end
`endif
  end

  assign bus.tail            = r_tail;
  assign bus.full            = w_full;
  assign bus.empty           = w_empty;
  assign bus.qry1_busy       = w_q1_busy;
  assign bus.qry1_value      = w_q1_value;
  assign bus.qry2_busy       = w_q2_busy;
  assign bus.qry2_value      = w_q2_value;
  assign bus.commit_valid    = r_commit_valid;
  assign bus.commit_id       = r_commit_id;
  assign bus.commit_rd       = r_commit_rd;
  assign bus.commit_value    = r_commit_value;
  assign bus.store_commit    = r_store_commit;
  assign bus.store_commit_id = r_store_commit_id;
  assign bus.flush           = r_flush;
  assign bus.flush_pc        = r_flush_pc;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: fill/full, in-order commit, latency,
// stores, branch flush, rdy_in pause and async reset mid-operation.
// Expected register-write commits are queued as stimulus is driven and
// compared each time the DUT pulses commit_valid.
module tb_reorder_buffer;
  import rob_pkg::*;

  logic clk_in = 1'b0;
  logic rst_n_in;
  logic rdy_in;

  reorder_buffer_if #(.BITS(ROB_BITS)) bus ();

  reorder_buffer #(.BITS(ROB_BITS), .SIZE(ROB_SIZE)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .rdy_in   (rdy_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] value;
  } exp_t;

  exp_t       q_exp[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] mt;    // model of tail

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_commit(input logic [3:0] id, input logic [4:0] rd, input logic [31:0] v);
    exp_t e;
    e.id = id; e.rd = rd; e.value = v;
    q_exp.push_back(e);
  endtask

  // Advance one edge and sample 1ns later; score any commit pulse.
  task automatic tick();
    exp_t e;
    @(posedge clk_in);
    #1;
    if (bus.commit_valid === 1'b1) begin
      if (q_exp.size() == 0) begin
        chk("unexpected_commit", 32'(bus.commit_valid), 32'd0);
      end else begin
        e = q_exp.pop_front();
        chk("commit_id", 32'(bus.commit_id), 32'(e.id));
        chk("commit_rd", 32'(bus.commit_rd), 32'(e.rd));
        chk("commit_value", bus.commit_value, e.value);
      end
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (q_exp.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(q_exp.size()), 32'd0);
  endtask

  task automatic idle();
    bus.issue_valid      = 1'b0;
    bus.issue_type       = 2'b00;
    bus.issue_rd         = '0;
    bus.issue_pc         = '0;
    bus.issue_pred_taken = 1'b0;
    bus.alu_valid        = 1'b0;
    bus.alu_id           = '0;
    bus.alu_value        = '0;
    bus.alu_taken        = 1'b0;
    bus.alu_target       = '0;
    bus.lsb_valid        = 1'b0;
    bus.lsb_id           = '0;
    bus.lsb_value        = '0;
  endtask

  task automatic drive_issue(input logic [1:0] typ, input logic [4:0] rd,
                             input logic [31:0] pc, input logic pred);
    bus.issue_valid      = 1'b1;
    bus.issue_type       = typ;
    bus.issue_rd         = rd;
    bus.issue_pc         = pc;
    bus.issue_pred_taken = pred;
  endtask

  task automatic drive_alu(input logic [3:0] id, input logic [31:0] v,
                           input logic taken, input logic [31:0] target);
    bus.alu_valid  = 1'b1;
    bus.alu_id     = id;
    bus.alu_value  = v;
    bus.alu_taken  = taken;
    bus.alu_target = target;
  endtask

  task automatic drive_lsb(input logic [3:0] id, input logic [31:0] v);
    bus.lsb_valid = 1'b1;
    bus.lsb_id    = id;
    bus.lsb_value = v;
  endtask

  initial begin
    rst_n_in    = 1'b0;
    rdy_in      = 1'b1;
    idle();
    bus.qry1_id = '0;
    bus.qry2_id = '0;
    mt          = '0;

    // ---------------- reset state
    #12;
    chk("rst_tail", 32'(bus.tail), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_commit_valid", 32'(bus.commit_valid), 32'd0);
    chk("rst_commit_value", bus.commit_value, 32'd0);
    chk("rst_store_commit", 32'(bus.store_commit), 32'd0);
    chk("rst_flush", 32'(bus.flush), 32'd0);
    chk("rst_flush_pc", bus.flush_pc, 32'd0);
    chk("rst_qry1_busy", 32'(bus.qry1_busy), 32'd1);
    chk("rst_qry1_value", bus.qry1_value, 32'd0);
    rst_n_in = 1'b1;
    tick();

    // ---------------- fill 16, 17th ignored
    for (int i = 0; i < 16; i++) begin
      drive_issue(2'b00, 5'(i), 32'h1000 + 32'(4 * i), 1'b0);
      chk("fill_tail", 32'(bus.tail), 32'(mt));
      tick();
      mt = mt + 4'd1;
    end
    chk("full_after16", 32'(bus.full), 32'd1);
    chk("tail_wrap", 32'(bus.tail), 32'd0);
    tick();   // 17th issue still asserted
    chk("ignored17_tail", 32'(bus.tail), 32'(mt));
    chk("ignored17_full", 32'(bus.full), 32'd1);
    idle();

    // drain: both writeback ports in the same cycle, commits in id order
    for (int i = 0; i < 16; i++) begin
      expect_commit(4'(i), 5'(i), 32'hA000 + 32'(i));
    end
    for (int k = 0; k < 8; k++) begin
      idle();
      drive_alu(4'(k), 32'hA000 + 32'(k), 1'b0, 32'd0);
      drive_lsb(4'(k + 8), 32'hA000 + 32'(k + 8));
      tick();
    end
    idle();
    drain("drain16");
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_full", 32'(bus.full), 32'd0);

    // ---------------- minimum latency: issue E0, writeback E1, commit after E2
    drive_issue(2'b00, 5'd5, 32'h2000, 1'b0);
    tick();
    mt = mt + 4'd1;
    chk("lat_tail", 32'(bus.tail), 32'(mt));
    idle();
    drive_alu(4'd0, 32'h1234, 1'b0, 32'd0);
    expect_commit(4'd0, 5'd5, 32'h1234);
    tick();
    idle();
    chk("lat_no_commit_e1", 32'(bus.commit_valid), 32'd0);
    tick();
    chk("lat_commit_e2", 32'(bus.commit_valid), 32'd1);
    tick();
    chk("lat_single_pulse", 32'(bus.commit_valid), 32'd0);

    // ---------------- out-of-order writeback, in-order commit (ids 1,2)
    drive_issue(2'b00, 5'd7, 32'h2004, 1'b0);
    tick();
    mt = mt + 4'd1;
    drive_issue(2'b11, 5'd8, 32'h2008, 1'b0);   // reserved type retires as reg-write
    tick();
    mt = mt + 4'd1;
    idle();
    expect_commit(4'd1, 5'd7, 32'hA);
    expect_commit(4'd2, 5'd8, 32'hB);
    drive_alu(4'd2, 32'hB, 1'b0, 32'd0);
    tick();
    idle();
    chk("ooo_hold", 32'(bus.commit_valid), 32'd0);
    drive_lsb(4'd1, 32'hA);
    tick();
    idle();
    drain("ooo_drain");

    // ---------------- query vs same-cycle writeback, store retire (id3)
    drive_issue(2'b01, 5'd0, 32'h200C, 1'b0);
    tick();
    mt = mt + 4'd1;
    idle();
    bus.qry1_id = 4'd3;
    drive_alu(4'd3, 32'h55, 1'b0, 32'd0);
    #1;
`ifdef ROB_BYPASS_EN
    chk("qry_bypass_busy", 32'(bus.qry1_busy), 32'd0);
    chk("qry_bypass_value", bus.qry1_value, 32'h55);
`else
    chk("qry_same_cycle_busy", 32'(bus.qry1_busy), 32'd1);
`endif
    tick();
    idle();
    chk("qry_next_busy", 32'(bus.qry1_busy), 32'd0);
    chk("qry_next_value", bus.qry1_value, 32'h55);
    tick();
    chk("store_commit", 32'(bus.store_commit), 32'd1);
    chk("store_commit_id", 32'(bus.store_commit_id), 32'd3);
    chk("store_no_commit_valid", 32'(bus.commit_valid), 32'd0);
    chk("qry_after_retire_busy", 32'(bus.qry1_busy), 32'd1);
    tick();
    chk("store_single_pulse", 32'(bus.store_commit), 32'd0);

    // ---------------- mispredict taken: branch id4 + 3 younger
    drive_issue(2'b10, 5'd0, 32'h100, 1'b0);
    tick();
    mt = mt + 4'd1;
    for (int i = 0; i < 3; i++) begin
      drive_issue(2'b00, 5'(10 + i), 32'h104 + 32'(4 * i), 1'b0);
      tick();
      mt = mt + 4'd1;
    end
    idle();
    drive_alu(4'd4, 32'd0, 1'b1, 32'h200);
    tick();
    idle();
    drive_issue(2'b00, 5'd20, 32'h300, 1'b0);   // dropped by flush
    drive_lsb(4'd5, 32'h77);                   // dropped by flush
    tick();
    mt = '0;
    idle();
    bus.qry2_id = 4'd5;
    chk("flush_pulse", 32'(bus.flush), 32'd1);
    chk("flush_pc_taken", bus.flush_pc, 32'h200);
    chk("flush_empty", 32'(bus.empty), 32'd1);
    chk("flush_tail", 32'(bus.tail), 32'd0);
    chk("flush_no_commit", 32'(bus.commit_valid), 32'd0);
    #1;
    chk("flush_drops_wb", 32'(bus.qry2_busy), 32'd1);
    tick();
    chk("flush_single_pulse", 32'(bus.flush), 32'd0);
    chk("flush_issue_dropped", 32'(bus.tail), 32'(mt));

    // ---------------- mispredict not-taken -> pc+4
    drive_issue(2'b10, 5'd0, 32'h300, 1'b1);
    tick();
    idle();
    drive_alu(4'd0, 32'd0, 1'b0, 32'h999);
    tick();
    idle();
    tick();
    chk("flush_nt_pulse", 32'(bus.flush), 32'd1);
    chk("flush_pc_fallthru", bus.flush_pc, 32'h304);

    // ---------------- correctly predicted branch retires silently
    drive_issue(2'b10, 5'd0, 32'h400, 1'b1);
    tick();
    mt = mt + 4'd1;
    idle();
    drive_alu(4'd0, 32'd0, 1'b1, 32'h500);
    tick();
    idle();
    tick();
    chk("br_ok_no_flush", 32'(bus.flush), 32'd0);
    chk("br_ok_no_commit", 32'(bus.commit_valid), 32'd0);
    chk("br_ok_empty", 32'(bus.empty), 32'd1);
    chk("br_ok_tail", 32'(bus.tail), 32'(mt));

    // ---------------- rdy_in low freezes state
    drive_issue(2'b00, 5'd9, 32'h600, 1'b0);
    tick();
    mt = mt + 4'd1;
    idle();
    drive_alu(4'd1, 32'h99, 1'b0, 32'd0);
    expect_commit(4'd1, 5'd9, 32'h99);
    tick();
    idle();
    rdy_in = 1'b0;
    drive_issue(2'b00, 5'd1, 32'h604, 1'b0);
    tick();
    chk("pause_no_commit", 32'(bus.commit_valid), 32'd0);
    chk("pause_tail_hold", 32'(bus.tail), 32'(mt));
    tick();
    chk("pause_no_commit2", 32'(bus.commit_valid), 32'd0);
    chk("pause_not_empty", 32'(bus.empty), 32'd0);
    idle();
    rdy_in = 1'b1;
    tick();
    chk("resume_commit", 32'(bus.commit_valid), 32'd1);
    chk("resume_empty", 32'(bus.empty), 32'd1);

    // ---------------- async reset with entries live and a commit pulse high
    for (int i = 0; i < 9; i++) begin
      drive_issue(2'b00, 5'(i + 1), 32'h700 + 32'(4 * i), 1'b0);
      tick();
      mt = mt + 4'd1;
    end
    idle();
    drive_alu(4'd2, 32'h42, 1'b0, 32'd0);
    expect_commit(4'd2, 5'd1, 32'h42);
    tick();
    idle();
    tick();
    chk("pre_rst_commit", 32'(bus.commit_valid), 32'd1);
    chk("pre_rst_empty", 32'(bus.empty), 32'd0);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("midrst_empty", 32'(bus.empty), 32'd1);
    chk("midrst_commit_valid", 32'(bus.commit_valid), 32'd0);
    chk("midrst_flush", 32'(bus.flush), 32'd0);
    chk("midrst_tail", 32'(bus.tail), 32'd0);
    #2;
    rst_n_in = 1'b1;
    mt = '0;
    tick();
    chk("post_rst_empty", 32'(bus.empty), 32'd1);
    chk("scoreboard_empty", 32'(q_exp.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
